// File: rtl/serial_subtractor_ctrl_if.sv
// serial_subtractor_ctrl_if
// Bundles the request/result handshake and the full-subtractor bit bus of
// serial_subtractor_ctrl.
//   start, a, b, bin   : operation request and operands (master -> slave)
//   busy, done         : progress / one-cycle completion pulse (slave -> master)
//   diff, bout         : result word and final borrow (slave -> master)
//   fs_x, fs_y, fs_z   : bit operands to the external full subtractor (slave -> master)
//   fs_diff, fs_borrow : bit results from the full subtractor (master -> slave)
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             fs_x;
  logic             fs_y;
  logic             fs_z;
  logic             fs_diff;
  logic             fs_borrow;

  modport master (
    output start, a, b, bin, fs_diff, fs_borrow,
    input  busy, done, diff, bout, fs_x, fs_y, fs_z
  );

  modport slave (
    input  start, a, b, bin, fs_diff, fs_borrow,
    output busy, done, diff, bout, fs_x, fs_y, fs_z
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Computes (a - b - bin) mod 2^WIDTH one bit per cycle, LSB first, using an
// external combinational full subtractor reached through the fs_* signals.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_ctrl_if.slave (request, result, full-subtractor bus)
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_subtractor_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             busy_reg;
  logic             done_reg;

  // Bit operands come straight from the registers while shifting so the
  // external full subtractor settles within the same cycle; forced low otherwise.
  assign bus.fs_x = (state == ST_SHIFT) & a_reg[0];
  assign bus.fs_y = (state == ST_SHIFT) & b_reg[0];
  assign bus.fs_z = (state == ST_SHIFT) & borrow_reg;

  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

  // Control FSM with registered busy/done. The result word is only written
  // on the final bit so diff/bout hold the previous answer during SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      borrow_reg <= 1'b0;
      cnt        <= '0;
      res        <= '0;
      diff_reg   <= '0;
      bout_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            borrow_reg <= bus.bin;
            cnt        <= '0;
            res        <= '0;
            busy_reg   <= 1'b1;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          res        <= {bus.fs_diff, res[WIDTH-1:1]};
          borrow_reg <= bus.fs_borrow;
          a_reg      <= a_reg >> 1;
          b_reg      <= b_reg >> 1;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            diff_reg <= {bus.fs_diff, res[WIDTH-1:1]};
            bout_reg <= bus.fs_borrow;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_reg <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl
// Drives serial_subtractor_ctrl (WIDTH=8) with directed and random operations,
// attaches a behavioural full subtractor to the fs_* bus and compares every
// result against plain integer arithmetic.
module tb_serial_subtractor_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   failures;

  serial_subtractor_ctrl_if #(.WIDTH(W)) bus();

  // Behavioural full subtractor hanging off the bit bus.
  assign bus.fs_diff   = bus.fs_x ^ bus.fs_y ^ bus.fs_z;
  assign bus.fs_borrow = (~bus.fs_x & bus.fs_y) | (~(bus.fs_x ^ bus.fs_y) & bus.fs_z);

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference result from integer arithmetic.
  function automatic logic [W-1:0] refDiff(input int av, input int bv, input int binv);
    int r;
    r = av - bv - binv;
    r = ((r % 256) + 256) % 256;
    return W'(r);
  endfunction

  function automatic logic refBout(input int av, input int bv, input int binv);
    return (av < bv + binv);
  endfunction

  // Issues one operation, optionally scrambles the operands after acceptance,
  // tracks busy/hold behaviour each cycle and checks the final result.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic binv, input bit scramble);
    logic [W-1:0] old_diff;
    logic         old_bout;
    int           lat;
    bit           seen;
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.bin = binv; bus.start = 1'b1;
    old_diff = bus.diff;
    old_bout = bus.bout;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("busy_after_start", {31'd0, bus.busy}, 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (lat < 3 * W && !seen) begin
      @(posedge clk);
      #1;
      lat++;
      if (scramble && lat == 3) begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
      end
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        checkOutput("busy_in_shift", {31'd0, bus.busy}, 32'd1);
        checkOutput("diff_hold", {23'd0, bus.bout, bus.diff}, {23'd0, old_bout, old_diff});
      end
    end
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    checkOutput("latency", lat, W);
    checkOutput("busy_in_done", {31'd0, bus.busy}, 32'd0);
    checkOutput("fs_zero_in_done", {29'd0, bus.fs_x, bus.fs_y, bus.fs_z}, 32'd0);
    checkOutput("diff", {24'd0, bus.diff}, {24'd0, refDiff(int'(av), int'(bv), int'(binv))});
    checkOutput("bout", {31'd0, bus.bout}, {31'd0, refBout(int'(av), int'(bv), int'(binv))});
    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    int pulses[$];
    int cyc;
    tests = 0;
    failures = 0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    rst_n = 1'b0;
    #12;
    checkOutput("reset_outputs", {24'd0, bus.busy, bus.done, bus.bout, bus.fs_x,
                                  bus.fs_y, bus.fs_z, 2'b00}, 32'd0);
    checkOutput("reset_diff", {24'd0, bus.diff}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases including borrow and wrap boundaries.
    applyStimulus(8'd200, 8'd55, 1'b0, 1'b0);
    applyStimulus(8'd5, 8'd10, 1'b0, 1'b0);
    applyStimulus(8'd0, 8'd0, 1'b1, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0);
    applyStimulus(8'd100, 8'd37, 1'b1, 1'b1);

    // Start held high: operations back to back, one per WIDTH+2 cycles.
    @(negedge clk);
    bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.start = 1'b1;
    for (cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses.push_back(cyc);
      if (bus.done && bus.busy) checkOutput("busy_done_exclusive", 32'd1, 32'd0);
    end
    bus.start = 1'b0;
    checkOutput("pulse_count_ge3", {31'd0, pulses.size() >= 3}, 32'd1);
    for (int i = 1; i < pulses.size(); i++)
      checkOutput("pulse_spacing", pulses[i] - pulses[i-1], W + 2);
    repeat (2 * W) @(posedge clk);

    // Reset in the middle of an operation aborts it immediately.
    applyStimulus(8'd9, 8'd3, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'h00; bus.bin = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("fs_x_active_before_reset", {31'd0, bus.fs_x}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_outputs", {26'd0, bus.busy, bus.done, bus.bout, bus.fs_x,
                                  bus.fs_y, bus.fs_z}, 32'd0);
    checkOutput("abort_diff", {24'd0, bus.diff}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("no_done_in_reset", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd77, 8'd200, 1'b1, 1'b0);

    // Random operations against the integer reference.
    for (int n = 0; n < 500; n++)
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
